uart_cfg_regs: RTL and testbench

- APB3 slave register block for UART configuration. It is the responder end of the configuration interface that the cfg agent drives as initiator.
- Holds the SETUP, STATUS, ERROR and IRQ_EN registers.
- Drives the static configuration into the UART tx/rx datapath and raises an error interrupt.
- Sits between the SoC APB fabric and the UART core.

---
 rtl/uart_cfg_pkg.sv | 41 ++++
 rtl/uart_cfg_apb_fsm.sv | 103 ++++++++++
 rtl/uart_cfg_regs.sv | 174 +++++++++++++++++
 tb/tb_uart_cfg_regs.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// UART configuration register block: shared types and constants.
// Register offsets, SETUP layout, reset values and APB FSM states.
package uart_cfg_pkg;

   typedef struct packed {
      logic [15:0] clk_div;
      logic        rx_en;
      logic        tx_en;
      logic        stop_bits;
      logic [1:0]  data_bits;
      logic        parity_en;
   } cfg_t;

   localparam int OFF_SETUP  = 'h00;
   localparam int OFF_STATUS = 'h04;
   localparam int OFF_ERROR  = 'h08;
   localparam int OFF_IRQ_EN = 'h0C;

   localparam logic [31:0] SETUP_RST = 32'h0000_0006;

   localparam cfg_t CFG_RST = '{
      clk_div:   16'h0000,
      rx_en:     1'b0,
      tx_en:     1'b0,
      stop_bits: 1'b0,
      data_bits: 2'b11,
      parity_en: 1'b0
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } apb_st_t;

   function automatic logic [31:0] cfg2word(cfg_t c);
      return {c.clk_div, 6'b0, c.rx_en, c.tx_en,
              4'b0, c.stop_bits, c.data_bits, c.parity_en};
   endfunction

endpackage

// File: rtl/uart_cfg_apb_fsm.sv
// APB3 responder handshake: wait-state counter, abort and slverr.
// Emits one-cycle commit strobes and read-data load controls.
import uart_cfg_pkg::*;

module uart_cfg_apb_fsm #(
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [ADDR_W-1:0] paddr_i,
   output logic              pready_o,
   output logic              pslverr_o,
   output logic              wr_stb,
   output logic              rd_stb,
   output logic              ld_rd,
   output logic              ld_zero,
   output logic [ADDR_W-1:0] addr
);

   apb_st_t    state_q;
   apb_st_t    state_nx;
   logic [2:0] cnt_q;
   logic [2:0] cnt_nx;
   logic       access;
   logic       bad;
   logic       enter;

   assign access = psel_i & penable_i & ~pready_o;

   assign bad = (paddr_i > ADDR_W'(OFF_IRQ_EN))
              | (paddr_i[1:0] != 2'b00)
              | (pwrite_i & ((paddr_i == ADDR_W'(OFF_STATUS))
                           | (paddr_i == ADDR_W'(OFF_ERROR))));

   assign enter = (state_nx == RESP) & (state_q != RESP);

   // state, wait counter and registered response flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         pready_o  <= 1'b0;
         pslverr_o <= 1'b0;
      end else begin
         state_q   <= state_nx;
         cnt_q     <= cnt_nx;
         pready_o  <= enter;
         pslverr_o <= enter & bad;
      end
   end

   // next state; the enable cycle counts as wait cycle 0, so
   // RESP is reached WAIT_STATES+1 edges after the first enable
   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (access) begin
               if (WAIT_STATES == 0) begin
                  state_nx = RESP;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = 3'd1;
               end
            end
         end
         WAIT: begin
            if (!psel_i) begin
               state_nx = IDLE;
               cnt_nx   = 3'd0;
            end else if (cnt_q == 3'(WAIT_STATES)) begin
               state_nx = RESP;
               cnt_nx   = 3'd0;
            end else begin
               cnt_nx = cnt_q + 3'd1;
            end
         end
         RESP: begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
         end
      endcase
   end

   // commit strobes during RESP, data load on entry to RESP
   always_comb begin
      wr_stb  = pready_o & pwrite_i & ~pslverr_o;
      rd_stb  = pready_o & ~pwrite_i & ~pslverr_o;
      ld_rd   = enter & ~pwrite_i & ~bad;
      ld_zero = enter & (pwrite_i | bad);
      addr    = paddr_i;
   end

endmodule

// File: rtl/uart_cfg_regs.sv
// UART configuration registers: SETUP, STATUS, ERROR, IRQ_EN.
// UART_CFG_SHADOW_EN defers SETUP writes until tx and rx are idle.
import uart_cfg_pkg::*;

module uart_cfg_regs #(
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic [31:0]       pwdata_i,
   output logic [31:0]       prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   input  logic              tx_busy_i,
   input  logic              rx_busy_i,
   input  logic              rx_ovf_i,
   input  logic              rx_par_err_i,
   output cfg_t              cfg_o,
   output logic              err_irq_o
);

   logic              wr_stb;
   logic              rd_stb;
   logic              ld_rd;
   logic              ld_zero;
   logic [ADDR_W-1:0] addr;

   logic              sel_setup;
   logic              sel_status;
   logic              sel_error;
   logic              sel_irq;

   cfg_t              cfg_q;
   cfg_t              wcfg;
   cfg_t              view;
   logic              pend;
   logic [1:0]        err_q;
   logic [1:0]        clr;
   logic [1:0]        irq_en_q;
   logic [31:0]       rdata;
   logic              unused_wdata;

   uart_cfg_apb_fsm #(
      .WAIT_STATES (WAIT_STATES),
      .ADDR_W      (ADDR_W)
   ) u_fsm (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .psel_i    (psel_i),
      .penable_i (penable_i),
      .pwrite_i  (pwrite_i),
      .paddr_i   (paddr_i),
      .pready_o  (pready_o),
      .pslverr_o (pslverr_o),
      .wr_stb    (wr_stb),
      .rd_stb    (rd_stb),
      .ld_rd     (ld_rd),
      .ld_zero   (ld_zero),
      .addr      (addr)
   );

   assign sel_setup  = (addr == ADDR_W'(OFF_SETUP));
   assign sel_status = (addr == ADDR_W'(OFF_STATUS));
   assign sel_error  = (addr == ADDR_W'(OFF_ERROR));
   assign sel_irq    = (addr == ADDR_W'(OFF_IRQ_EN));

   assign wcfg = '{
      clk_div:   pwdata_i[31:16],
      rx_en:     pwdata_i[9],
      tx_en:     pwdata_i[8],
      stop_bits: pwdata_i[3],
      data_bits: pwdata_i[2:1],
      parity_en: pwdata_i[0]
   };

   assign unused_wdata = ^{pwdata_i[15:10], pwdata_i[7:4]};

   assign clr   = {2{rd_stb & sel_error}};
   assign cfg_o = cfg_q;

`ifdef UART_CFG_SHADOW_EN
   cfg_t shadow_q;
   logic pend_q;

   assign view = shadow_q;
   assign pend = pend_q;

   // shadow capture and deferred apply while the datapath is idle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= CFG_RST;
         pend_q   <= 1'b0;
         cfg_q    <= CFG_RST;
      end else begin
         if (pend_q && !tx_busy_i && !rx_busy_i) begin
            cfg_q  <= shadow_q;
            pend_q <= 1'b0;
         end
         if (wr_stb && sel_setup) begin
            shadow_q <= wcfg;
            pend_q   <= 1'b1;
         end
      end
   end
`else
   assign view = cfg_q;
   assign pend = 1'b0;

   // direct SETUP update on the write edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cfg_q <= CFG_RST;
      end else if (wr_stb && sel_setup) begin
         cfg_q <= wcfg;
      end
   end
`endif

   // sticky error bits; a new pulse wins over a read-clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 2'b00;
      end else begin
         err_q <= (err_q & ~clr) | {rx_par_err_i, rx_ovf_i};
      end
   end

   // interrupt enables
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_en_q <= 2'b00;
      end else if (wr_stb && sel_irq) begin
         irq_en_q <= pwdata_i[1:0];
      end
   end

   // registered level interrupt
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_irq_o <= 1'b0;
      end else begin
         err_irq_o <= |(err_q & irq_en_q);
      end
   end

   // read mux
   always_comb begin
      rdata = 32'h0;
      unique case (1'b1)
         sel_setup:  rdata = cfg2word(view);
         sel_status: rdata = {29'b0, pend, rx_busy_i, tx_busy_i};
         sel_error:  rdata = {30'b0, err_q};
         sel_irq:    rdata = {30'b0, irq_en_q};
         default:    rdata = 32'h0;
      endcase
   end

   // read data loaded on entry to RESP, held otherwise
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prdata_o <= 32'h0;
      end else if (ld_zero) begin
         prdata_o <= 32'h0;
      end else if (ld_rd) begin
         prdata_o <= rdata;
      end
   end

endmodule

// File: tb/tb_uart_cfg_regs.sv
// Bench for uart_cfg_regs with two wait states.
// Scoreboard queue of expected responses checked by a monitor.
import uart_cfg_pkg::*;

module tb_uart_cfg_regs;

   logic        clk;
   logic        rst;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        tx_busy;
   logic        rx_busy;
   logic        rx_ovf;
   logic        rx_par;
   cfg_t        cfg;
   logic        irq;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [15:0] id;
   } exp_t;

   exp_t q[$];
   int   n_cmp;
   int   n_bad;
   int   tid;

   uart_cfg_regs #(
      .WAIT_STATES (2),
      .ADDR_W      (5)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .psel_i       (psel),
      .penable_i    (penable),
      .pwrite_i     (pwrite),
      .paddr_i      (paddr),
      .pwdata_i     (pwdata),
      .prdata_o     (prdata),
      .pready_o     (pready),
      .pslverr_o    (pslverr),
      .tx_busy_i    (tx_busy),
      .rx_busy_i    (rx_busy),
      .rx_ovf_i     (rx_ovf),
      .rx_par_err_i (rx_par),
      .cfg_o        (cfg),
      .err_irq_o    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] tbw(cfg_t c);
      return {c.clk_div, 6'b0, c.rx_en, c.tx_en,
              4'b0, c.stop_bits, c.data_bits, c.parity_en};
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apb(input logic        wr,
                      input logic [4:0]  a,
                      input logic [31:0] d,
                      input logic [31:0] exp_rd,
                      input logic        exp_err,
                      input bit          ovf_resp);
      exp_t e;
      int   lat;
      bit   got;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.id    = 16'(tid);
      tid++;
      q.push_back(e);
      cyc(1);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      cyc(1);
      penable = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         cyc(1);
         lat++;
         if (pready) got = 1'b1;
      end
      chk($sformatf("latency_txn%0d", e.id), 32'(lat), 32'd3);
      if (ovf_resp) rx_ovf = 1'b1;
      cyc(1);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      rx_ovf  = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a,
                     input logic [31:0] exp_rd,
                     input logic exp_err);
      apb(1'b0, a, 32'h0, exp_rd, exp_err, 1'b0);
   endtask

   task automatic wr(input logic [4:0] a,
                     input logic [31:0] d,
                     input logic exp_err);
      apb(1'b1, a, d, 32'h0, exp_err, 1'b0);
   endtask

   task automatic pulse_ovf();
      rx_ovf = 1'b1;
      cyc(1);
      rx_ovf = 1'b0;
   endtask

   // monitor: compare each response against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && pready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pready: got 1 want 0");
            end else begin
               e = q.pop_front();
               chk($sformatf("prdata_txn%0d", e.id), prdata, e.rdata);
               chk($sformatf("pslverr_txn%0d", e.id),
                   32'(pslverr), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      n_cmp   = 0;
      n_bad   = 0;
      tid     = 0;
      rst     = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 5'h0;
      pwdata  = 32'h0;
      tx_busy = 1'b0;
      rx_busy = 1'b0;
      rx_ovf  = 1'b0;
      rx_par  = 1'b0;
      cyc(3);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_pready", 32'(pready), 32'h0);
      chk("rst_pslverr", 32'(pslverr), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_cfg", tbw(cfg), 32'h0000_0006);
      rst = 1'b0;
      cyc(2);

      rd(5'h00, 32'h0000_0006, 1'b0);
      rd(5'h0C, 32'h0, 1'b0);
      rd(5'h04, 32'h0, 1'b0);
      rd(5'h08, 32'h0, 1'b0);

      wr(5'h00, 32'h0123_030B, 1'b0);
      cyc(1);
      chk("cfg_word", tbw(cfg), 32'h0123_030B);
      chk("cfg_clk_div", 32'(cfg.clk_div), 32'h0123);
      chk("cfg_data_bits", 32'(cfg.data_bits), 32'h1);
      chk("cfg_flags", 32'({cfg.parity_en, cfg.stop_bits,
                            cfg.tx_en, cfg.rx_en}), 32'hF);
      rd(5'h00, 32'h0123_030B, 1'b0);
      wr(5'h00, 32'hFFFF_FFFF, 1'b0);
      rd(5'h00, 32'hFFFF_030F, 1'b0);
      wr(5'h00, 32'h0123_030B, 1'b0);
      cyc(1);
      chk("cfg_restore", tbw(cfg), 32'h0123_030B);

      tx_busy = 1'b1;
`ifdef UART_CFG_SHADOW_EN
      wr(5'h00, 32'h0000_0105, 1'b0);
      rd(5'h04, 32'h0000_0005, 1'b0);
      chk("shadow_hold", tbw(cfg), 32'h0123_030B);
      rd(5'h00, 32'h0000_0105, 1'b0);
      wr(5'h00, 32'h0000_0207, 1'b0);
      rd(5'h00, 32'h0000_0207, 1'b0);
      chk("shadow_hold2", tbw(cfg), 32'h0123_030B);
      tx_busy = 1'b0;
      chk("shadow_pre_edge", tbw(cfg), 32'h0123_030B);
      cyc(1);
      chk("shadow_apply", tbw(cfg), 32'h0000_0207);
      rd(5'h04, 32'h0, 1'b0);
`else
      rx_busy = 1'b1;
      rd(5'h04, 32'h0000_0003, 1'b0);
      wr(5'h00, 32'h0000_0207, 1'b0);
      chk("direct_apply", tbw(cfg), 32'h0000_0207);
      tx_busy = 1'b0;
      rx_busy = 1'b0;
      rd(5'h04, 32'h0, 1'b0);
`endif

      wr(5'h0C, 32'h0000_0002, 1'b0);
      rx_par = 1'b1;
      cyc(1);
      rx_par = 1'b0;
      cyc(1);
      chk("irq_par_set", 32'(irq), 32'h1);
      rd(5'h08, 32'h0000_0002, 1'b0);
      chk("irq_lag", 32'(irq), 32'h1);
      cyc(1);
      chk("irq_clear", 32'(irq), 32'h0);
      rd(5'h08, 32'h0, 1'b0);

      pulse_ovf();
      cyc(1);
      chk("irq_ovf_masked", 32'(irq), 32'h0);
      apb(1'b0, 5'h08, 32'h0, 32'h0000_0001, 1'b0, 1'b1);
      rd(5'h08, 32'h0000_0001, 1'b0);
      rd(5'h08, 32'h0, 1'b0);
      wr(5'h0C, 32'h0000_0003, 1'b0);
      pulse_ovf();
      cyc(1);
      chk("irq_ovf_en", 32'(irq), 32'h1);
      rd(5'h08, 32'h0000_0001, 1'b0);
      wr(5'h0C, 32'h0000_0002, 1'b0);

      rd(5'h00, 32'h0000_0207, 1'b0);
      rd(5'h10, 32'h0, 1'b1);
      wr(5'h04, 32'hFFFF_FFFF, 1'b1);
      wr(5'h08, 32'hFFFF_FFFF, 1'b1);
      rd(5'h02, 32'h0, 1'b1);
      wr(5'h01, 32'h0000_0000, 1'b1);
      wr(5'h1C, 32'h0000_0003, 1'b1);
      rd(5'h00, 32'h0000_0207, 1'b0);
      rd(5'h0C, 32'h0000_0002, 1'b0);
      rd(5'h08, 32'h0, 1'b0);

      cyc(1);
      psel    = 1'b1;
      pwrite  = 1'b1;
      paddr   = 5'h0C;
      pwdata  = 32'h0000_0001;
      cyc(1);
      penable = 1'b1;
      cyc(1);
      psel    = 1'b0;
      penable = 1'b0;
      seen    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (pready) seen = 1'b1;
      end
      chk("abort_no_pready", 32'(seen), 32'h0);
      rd(5'h0C, 32'h0000_0002, 1'b0);

      pulse_ovf();
      cyc(1);
      psel    = 1'b1;
      pwrite  = 1'b0;
      paddr   = 5'h00;
      cyc(1);
      penable = 1'b1;
      cyc(1);
      rst = 1'b1;
      #1;
      chk("midrst_pready", 32'(pready), 32'h0);
      chk("midrst_cfg", tbw(cfg), 32'h0000_0006);
      psel    = 1'b0;
      penable = 1'b0;
      cyc(1);
      rst = 1'b0;
      cyc(3);
      chk("midrst_no_pready", 32'(pready), 32'h0);
      chk("midrst_irq", 32'(irq), 32'h0);
      rd(5'h00, 32'h0000_0006, 1'b0);
      rd(5'h0C, 32'h0, 1'b0);
      rd(5'h08, 32'h0, 1'b0);

      for (int i = 0; i < 50 && q.size() != 0; i++) cyc(1);
      chk("scoreboard_empty", 32'(q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
